// File: rtl/mem_channel_arbiter_pkg.sv
// Shared definitions for the memory channel arbiter.
// Contents: access width and arbiter state enums, the read-tracking entry
// type, and the round-robin pointer helper.
package mem_channel_arbiter_pkg;

  typedef enum logic {
    SINGLE_WIDTH = 1'b0,
    DOUBLE_WIDTH = 1'b1
  } DataWidth_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_SECOND = 1'b1
  } ArbState_t;

  // Channel index field sized for the largest supported channel count (8).
  localparam int unsigned CH_IDX_W = 3;

  // One in-flight read beat travelling alongside the bank read latency.
  typedef struct packed {
    logic                vld;
    logic [CH_IDX_W-1:0] ch;
    logic                last;
    logic                dbl;
  } rd_track_t;

  // Round-robin successor of idx among n channels.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/mem_channel_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting channel at or after rr_ptr_i.
// Ports:
//   req_i       - per-channel request vector
//   rr_ptr_i    - highest-priority channel index this cycle
//   advance_i   - arbitration enabled this cycle; when low no grant is made
//   grant_oh_o  - one-hot grant
//   grant_idx_o - binary index of the granted channel (0 when no grant)
module mem_channel_arbiter_rr_arbiter #(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  rr_ptr_i,
  input  logic              advance_i,
  output logic [NUM_CH-1:0] grant_oh_o,
  output logic [IDX_W-1:0]  grant_idx_o
);

  int unsigned idx;
  logic        found;

  // Scan channels starting at the pointer; first requester wins.
  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 32'd0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(rr_ptr_i) + i) % NUM_CH;
      if (advance_i && !found && req_i[IDX_W'(idx)]) begin
        found                     = 1'b1;
        grant_oh_o[IDX_W'(idx)]   = 1'b1;
        grant_idx_o               = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// N-channel round-robin port onto one single-port memory bank. Double-width
// accesses are split into two consecutive beats; reads are tracked through a
// READ_LAT-deep pipeline and returned to the originating channel.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   req_valid/req_ready       - per-channel request handshake
//   req_write/req_width       - per-channel direction and access width
//   req_addr/req_wdata        - per-channel base address and 2-word write data
//   rsp_valid/rsp_rdata       - one-hot read response strobe and shared data
//   bank_en/bank_chip_en      - bank access enable, 1 = write beat
//   bank_addr/bank_wdata      - bank address and write word
//   bank_rdata                - bank read word, READ_LAT cycles after a read beat
module mem_channel_arbiter
  import mem_channel_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned READ_LAT = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CH-1:0]                  req_valid,
  output logic [NUM_CH-1:0]                  req_ready,
  input  logic [NUM_CH-1:0]                  req_write,
  input  DataWidth_t                         req_width [NUM_CH],
  input  logic [NUM_CH-1:0][ADDR_W-1:0]      req_addr,
  input  logic [NUM_CH-1:0][2*DATA_W-1:0]    req_wdata,
  output logic [NUM_CH-1:0]                  rsp_valid,
  output logic [2*DATA_W-1:0]                rsp_rdata,
  output logic                               bank_en,
  output logic                               bank_chip_en,
  output logic [ADDR_W-1:0]                  bank_addr,
  output logic [DATA_W-1:0]                  bank_wdata,
  input  logic [DATA_W-1:0]                  bank_rdata
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  ArbState_t             state_q, state_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]       lat_ch_q, lat_ch_d;
  logic [ADDR_W-1:0]     lat_addr_q, lat_addr_d;
  logic                  lat_write_q, lat_write_d;
  logic [DATA_W-1:0]     lat_whi_q, lat_whi_d;
  logic [ADDR_W-1:0]     last_addr_q;
  logic [DATA_W-1:0]     last_wdata_q;
  rd_track_t             pipe_q [READ_LAT];
  rd_track_t             issue;
  rd_track_t             ret;
  logic [DATA_W-1:0]     low_q, low_d;
  logic [NUM_CH-1:0]     rsp_valid_q, rsp_valid_d;
  logic [2*DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [NUM_CH-1:0]     grant_oh;
  logic [CH_W-1:0]       grant_idx;
  logic                  advance;

  // Arbitrate only between transactions and never while reset is asserted.
  assign advance = (state_q == ARB_IDLE) && !rst;

  mem_channel_arbiter_rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
    .req_i       (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .advance_i   (advance),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_idx)
  );

  // Beat issue, handshake and next-state logic.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lat_ch_d     = lat_ch_q;
    lat_addr_d   = lat_addr_q;
    lat_write_d  = lat_write_q;
    lat_whi_d    = lat_whi_q;
    req_ready    = '0;
    bank_en      = 1'b0;
    bank_chip_en = 1'b0;
    bank_addr    = last_addr_q;
    bank_wdata   = last_wdata_q;
    issue        = '0;
    case (state_q)
      ARB_IDLE: begin
        if (|grant_oh) begin
          bank_en      = 1'b1;
          bank_chip_en = req_write[grant_idx];
          bank_addr    = req_addr[grant_idx];
          bank_wdata   = req_wdata[grant_idx][DATA_W-1:0];
          issue.vld    = !req_write[grant_idx];
          issue.ch     = CH_IDX_W'(grant_idx);
          if (req_width[grant_idx] == SINGLE_WIDTH) begin
            req_ready  = grant_oh;
            rr_ptr_d   = CH_W'(rr_next(32'(grant_idx), NUM_CH));
            issue.last = 1'b1;
          end else begin
            // Latch the transaction so beat 1 does not depend on the requester.
            lat_ch_d    = grant_idx;
            lat_addr_d  = req_addr[grant_idx];
            lat_write_d = req_write[grant_idx];
            lat_whi_d   = req_wdata[grant_idx][2*DATA_W-1:DATA_W];
            issue.dbl   = 1'b1;
            state_d     = ARB_SECOND;
          end
        end
      end
      ARB_SECOND: begin
        bank_en             = 1'b1;
        bank_chip_en        = lat_write_q;
        bank_addr           = lat_addr_q + ADDR_W'(1);
        bank_wdata          = lat_whi_q;
        req_ready[lat_ch_q] = 1'b1;
        rr_ptr_d            = CH_W'(rr_next(32'(lat_ch_q), NUM_CH));
        issue.vld           = !lat_write_q;
        issue.ch            = CH_IDX_W'(lat_ch_q);
        issue.last          = 1'b1;
        issue.dbl           = 1'b1;
        state_d             = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign ret = pipe_q[READ_LAT-1];

  // Read return: hold beat 0 of a double read, respond on the last beat.
  always_comb begin
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    low_d       = low_q;
    if (ret.vld) begin
      if (ret.last) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          rsp_valid_d[i] = (ret.ch == CH_IDX_W'(i));
        end
        rsp_rdata_d = ret.dbl ? {bank_rdata, low_q} : {{DATA_W{1'b0}}, bank_rdata};
      end else begin
        low_d = bank_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= '0;
      lat_ch_q     <= '0;
      lat_addr_q   <= '0;
      lat_write_q  <= 1'b0;
      lat_whi_q    <= '0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
      low_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lat_ch_q     <= lat_ch_d;
      lat_addr_q   <= lat_addr_d;
      lat_write_q  <= lat_write_d;
      lat_whi_q    <= lat_whi_d;
      last_addr_q  <= bank_addr;
      last_wdata_q <= bank_wdata;
      low_q        <= low_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      pipe_q[0]    <= issue;
      for (int i = 1; i < READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/mem_channel_arbiter.md
# mem_channel_arbiter

Parametrised N-channel memory port that lets several compute requesters share one single-port memory bank. It performs round-robin arbitration, splits double-width accesses into two consecutive bank beats, and tracks in-flight reads through a fixed-latency pipeline. Read responses are returned to the originating channel. It sits between the compute blocks and each memory bank, replacing point-to-point read/write hookups.

## Interface
Parameters:
- NUM_CH, 4: number of requesting channels (2..8)
- DATA_W, 16: bank word width
- ADDR_W, 16: bank address width
- READ_LAT, 2: bank read latency in cycles (1..4)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_CH  per-channel request valid
- req_ready  out  NUM_CH  per-channel accept; a request is consumed on valid&ready
- req_write  in  NUM_CH  1 = write, 0 = read
- req_width  in  NUM_CH x DataWidth_t  SINGLE_WIDTH (1 beat) or DOUBLE_WIDTH (2 beats)
- req_addr  in  NUM_CH x ADDR_W  base address
- req_wdata  in  NUM_CH x 2*DATA_W  write data; low word at addr, high word at addr+1
- rsp_valid  out  NUM_CH  one-hot read-response strobe
- rsp_rdata  out  2*DATA_W  shared read data, qualified by rsp_valid
- bank_en  out  1  bank access enable
- bank_chip_en  out  1  1 = write beat, 0 = read beat
- bank_addr  out  ADDR_W  bank address
- bank_wdata  out  DATA_W  bank write word
- bank_rdata  in  DATA_W  bank read word, valid READ_LAT cycles after a read beat

## Operation
- FSM ArbState_t: ARB_IDLE, ARB_SECOND.
- ARB_IDLE: the round-robin arbiter picks the first valid channel at or after rr_ptr. It issues beat 0 (addr, low word) the same cycle.
  - SINGLE_WIDTH: req_ready of the granted channel is high that cycle. rr_ptr moves to grant+1 mod NUM_CH. The FSM stays in ARB_IDLE.
  - DOUBLE_WIDTH: the grant is latched, req_ready stays low, and the FSM goes to ARB_SECOND.
- ARB_SECOND: issues beat 1 (addr+1, high word) for the latched channel, ignoring other channels. req_ready of the latched channel is high that cycle. rr_ptr advances, then the FSM returns to ARB_IDLE.
- Requester holds valid and all request fields stable until ready. A drop of valid in ARB_SECOND is a protocol violation; beat 1 is still issued.
- addr+1 wraps modulo 2^ADDR_W (0xFFFF -> 0x0000 at ADDR_W=16).
- Read tracking: a READ_LAT-deep shift register of {valid, ch, last_beat}.
  - A beat-0 word of a double read is stored in a low-word holding register.
  - On the last beat's return, rsp_rdata = {bank_rdata, low} for double reads, or {DATA_W'0, bank_rdata} for single reads. rsp_valid[ch] pulses one cycle.
- Writes generate no response; ready is the completion acknowledgement.
- Throughput: one bank beat per cycle. Back-to-back grants are allowed with no idle cycle.
- Reset (asynchronous, mid-operation included): FSM -> ARB_IDLE, rr_ptr -> 0, tracking pipeline cleared, in-flight reads dropped (no rsp_valid).

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, bank_en=0, bank_chip_en=0, bank_addr=0, bank_wdata=0.
- bank_* and req_ready are combinational from FSM state and the arbiter. They are valid in the issue cycle.
- rsp_valid/rsp_rdata are registered. They assert READ_LAT+1 cycles after the last read beat is issued.
- Single read latency = READ_LAT+1 cycles. Double read latency = READ_LAT+2 cycles from first issue.
- No channel idle: bank_en=0, and bank_addr/bank_wdata hold their last value.

## Structure
- Add ArbState_t to the shared Defines package. Reuse DataWidth_t there.
- Sub-module rr_arbiter (NUM_CH param): inputs req vector, rr_ptr and an advance strobe; outputs a one-hot grant and the grant index.
- Tracking pipeline and word assembly stay inline.

## Test plan
- Ch0 single read at 0x0010, bank returns 0x1234 -> bank_en 1 cycle, rsp_valid=0b0001 after READ_LAT+1 cycles, rsp_rdata=0x00001234.
- Ch2 double write at 0xFFFF, data 0xBEEF_CAFE -> beats at 0xFFFF (0xCAFE) and 0x0000 (0xBEEF), req_ready high only on the second beat.
- All 4 channels issue single reads continuously -> grants in order 0,1,2,3,0, one beat per cycle, each rsp_valid routed to the correct channel.
- Ch1 double read while ch3 is valid -> ch3 is not granted until ARB_SECOND completes, and rsp_rdata = {beat1, beat0}.
- Assert rst one cycle after issuing two reads -> no rsp_valid ever appears and all outputs are at reset values. The first post-reset grant goes to ch0.
